// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icode, condition, stat and condition-code reset constants
package y86_pkg;
  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_NOP = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ = 4'h6;
  localparam logic [3:0] I_JXX = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET = 4'h9;
  localparam logic [3:0] I_PUSHQ = 4'hA;
  localparam logic [3:0] I_POPQ = 4'hB;
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE = 4'h1;
  localparam logic [3:0] C_L = 4'h2;
  localparam logic [3:0] C_E = 4'h3;
  localparam logic [3:0] C_NE = 4'h4;
  localparam logic [3:0] C_GE = 4'h5;
  localparam logic [3:0] C_G = 4'h6;
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;
  localparam logic [2:0] CC_RST = 3'b100;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational jXX/cmovXX condition from {zf,sf,of} and ifun
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] i_cc,
  input  logic [3:0] i_ifun,
  output logic       o_cnd
);
  logic w_zf, w_lt;
  always_comb begin
    w_zf = i_cc[2];
    w_lt = i_cc[1] ^ i_cc[0];
    o_cnd = i_ifun == C_YES ? 1'b1 :
            i_ifun == C_LE  ? w_lt | w_zf :
            i_ifun == C_L   ? w_lt :
            i_ifun == C_E   ? w_zf :
            i_ifun == C_NE  ? ~w_zf :
            i_ifun == C_GE  ? ~w_lt :
            i_ifun == C_G   ? ~w_lt & ~w_zf : 1'b0;
  end
endmodule

// File: rtl/cc_unit.sv
// cc_unit: execute-stage condition-code register, condition evaluation and mispredict flag
module cc_unit #(
  parameter int         W      = 64,
  parameter logic [2:0] CC_RST = y86_pkg::CC_RST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   e_icode,
  input  logic [3:0]   e_ifun,
  input  logic [W-1:0] alu_res,
  input  logic         alu_of,
  input  logic         e_bubble,
  input  logic         exc_down,
  input  logic         stall_e,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         e_cnd,
  output logic         mispredict
);
  logic [2:0] r_cc;
  logic       w_set, w_cnd;
  cond_eval u_cond (.i_cc(r_cc), .i_ifun(e_ifun), .o_cnd(w_cnd));
  always_comb begin
    w_set = e_icode == y86_pkg::I_OPQ && !e_bubble && !exc_down && !stall_e;
    {zf, sf, of} = r_cc;
    e_cnd = (e_icode == y86_pkg::I_JXX || e_icode == y86_pkg::I_RRMOVQ) ? w_cnd : 1'b0;
    mispredict = e_icode == y86_pkg::I_JXX && !e_bubble && !e_cnd;
  end
  always_ff @(posedge clk)
    if (rst) r_cc <= CC_RST;
    else if (w_set) r_cc <= {~|alu_res, alu_res[W-1], alu_of};
endmodule

// File: tb/tb_cc_unit.sv
// tb_cc_unit: directed self-checking bench for cc_unit
module tb_cc_unit;
  logic        clk = 0;
  logic        rst = 0;
  logic [3:0]  e_icode = 4'h1;
  logic [3:0]  e_ifun = 0;
  logic [63:0] alu_res = 0;
  logic        alu_of = 0;
  logic        e_bubble = 0;
  logic        exc_down = 0;
  logic        stall_e = 0;
  logic        zf, sf, of, e_cnd, mispredict;
  int n_vec = 0;
  int n_err = 0;

  cc_unit dut (
    .clk(clk), .rst(rst), .e_icode(e_icode), .e_ifun(e_ifun), .alu_res(alu_res),
    .alu_of(alu_of), .e_bubble(e_bubble), .exc_down(exc_down), .stall_e(stall_e),
    .zf(zf), .sf(sf), .of(of), .e_cnd(e_cnd), .mispredict(mispredict)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic z, input logic s, input logic o);
    e_icode = 4'h6;
    alu_res = z ? 64'd0 : (s ? 64'h8000_0000_0000_0000 : 64'd1);
    alu_of = o;
    cyc();
    e_icode = 4'h1;
    alu_of = 0;
  endtask

  function automatic logic exp_cnd(input logic z, input logic s, input logic o, input int f);
    case (f)
      0: return 1'b1;
      1: return (s != o) || z;
      2: return s != o;
      3: return z;
      4: return !z;
      5: return s == o;
      6: return (s == o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1;
    cyc();
    rst = 0;
    n_vec++;
    if ({zf, sf, of} !== 3'b100) begin n_err++; $display("FAIL reset_cc got %b want 100", {zf, sf, of}); end
    e_icode = 4'h7; e_ifun = 4'd3; #1;
    n_vec++;
    if ({e_cnd, mispredict} !== 2'b10) begin n_err++; $display("FAIL reset_je got cnd/mp %b want 10", {e_cnd, mispredict}); end
  endtask

  task automatic test_write_latency();
    load(0, 0, 0);
    e_icode = 4'h6; e_ifun = 4'd1; alu_res = 0; alu_of = 0; #1;
    n_vec++;
    if ({zf, sf, of, e_cnd} !== 4'b0000) begin n_err++; $display("FAIL subq_pre got zf/sf/of/cnd %b want 0000", {zf, sf, of, e_cnd}); end
    cyc();
    e_icode = 4'h7; e_ifun = 4'd1; #1;
    n_vec++;
    if ({zf, sf, of} !== 3'b100) begin n_err++; $display("FAIL subq_cc got %b want 100", {zf, sf, of}); end
    n_vec++;
    if ({e_cnd, mispredict} !== 2'b10) begin n_err++; $display("FAIL subq_jle got cnd/mp %b want 10", {e_cnd, mispredict}); end
  endtask

  task automatic test_overflow();
    e_icode = 4'h6; e_ifun = 0; alu_res = 64'h8000_0000_0000_0000; alu_of = 1;
    cyc();
    alu_of = 0;
    e_icode = 4'h7; e_ifun = 4'd2; #1;
    n_vec++;
    if ({zf, sf, of} !== 3'b011) begin n_err++; $display("FAIL addq_cc got %b want 011", {zf, sf, of}); end
    n_vec++;
    if ({e_cnd, mispredict} !== 2'b01) begin n_err++; $display("FAIL addq_jl got cnd/mp %b want 01", {e_cnd, mispredict}); end
    cyc();
    e_ifun = 4'd5; #1;
    n_vec++;
    if ({e_cnd, mispredict} !== 2'b10) begin n_err++; $display("FAIL addq_jge got cnd/mp %b want 10", {e_cnd, mispredict}); end
    e_icode = 4'h2; e_ifun = 4'd2; #1;
    n_vec++;
    if ({e_cnd, mispredict} !== 2'b00) begin n_err++; $display("FAIL cmovl got cnd/mp %b want 00", {e_cnd, mispredict}); end
    e_icode = 4'h7; e_bubble = 1; #1;
    n_vec++;
    if (mispredict !== 1'b0) begin n_err++; $display("FAIL bubble_jl got mp %b want 0", mispredict); end
    e_bubble = 0;
  endtask

  task automatic test_suppress();
    load(1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      e_icode = 4'h6; alu_res = 64'hFFFF_FFFF_FFFF_FFFB; alu_of = 1;
      exc_down = k == 0; e_bubble = k == 1; stall_e = k == 2;
      cyc();
      exc_down = 0; e_bubble = 0; stall_e = 0; e_icode = 4'h1; alu_of = 0;
      n_vec++;
      if ({zf, sf, of} !== 3'b100) begin n_err++; $display("FAIL suppress_%0d got %b want 100", k, {zf, sf, of}); end
    end
    e_icode = 4'h6; alu_res = 64'hFFFF_FFFF_FFFF_FFFB;
    cyc();
    e_icode = 4'h1;
    n_vec++;
    if ({zf, sf, of} !== 3'b010) begin n_err++; $display("FAIL unsuppressed got %b want 010", {zf, sf, of}); end
  endtask

  task automatic test_sweep();
    logic [2:0] combos [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
    logic [2:0] c;
    for (int i = 0; i < 6; i++) begin
      c = combos[i];
      load(c[2], c[1], c[0]);
      e_icode = 4'h7;
      for (int f = 0; f < 16; f++) begin
        e_ifun = f[3:0]; #1;
        n_vec++;
        if (e_cnd !== exp_cnd(c[2], c[1], c[0], f) || mispredict !== !exp_cnd(c[2], c[1], c[0], f)) begin
          n_err++;
          $display("FAIL sweep cc=%b ifun=%0d got cnd/mp %b%b want %b%b", c, f, e_cnd, mispredict,
                   exp_cnd(c[2], c[1], c[0], f), !exp_cnd(c[2], c[1], c[0], f));
        end
      end
    end
    e_ifun = 0;
    for (int ic = 0; ic < 16; ic++) begin
      if (ic == 2 || ic == 7) continue;
      e_icode = ic[3:0]; #1;
      n_vec++;
      if ({e_cnd, mispredict} !== 2'b00) begin n_err++; $display("FAIL icode_%0d got cnd/mp %b want 00", ic, {e_cnd, mispredict}); end
    end
    e_icode = 4'h1;
  endtask

  task automatic test_reset_mid();
    load(0, 1, 0);
    rst = 1; e_icode = 4'h6; alu_res = 64'd7; alu_of = 1;
    cyc();
    rst = 0; alu_of = 0;
    e_icode = 4'h7; e_ifun = 4'd4; #1;
    n_vec++;
    if ({zf, sf, of} !== 3'b100) begin n_err++; $display("FAIL rst_mid got %b want 100", {zf, sf, of}); end
    n_vec++;
    if ({e_cnd, mispredict} !== 2'b01) begin n_err++; $display("FAIL rst_mid_jne got cnd/mp %b want 01", {e_cnd, mispredict}); end
    e_icode = 4'h6; alu_res = 64'd7;
    cyc();
    e_icode = 4'h7; #1;
    n_vec++;
    if ({zf, sf, of} !== 3'b000) begin n_err++; $display("FAIL post_rst_opq got %b want 000", {zf, sf, of}); end
    n_vec++;
    if ({e_cnd, mispredict} !== 2'b10) begin n_err++; $display("FAIL post_rst_jne got cnd/mp %b want 10", {e_cnd, mispredict}); end
  endtask

  initial begin
    cyc();
    test_reset();
    test_write_latency();
    test_overflow();
    test_suppress();
    test_sweep();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
